// File: rtl/rf_gather_mac.sv
// rf_gather_mac: gathers input activations for in-bounds sparse-weight
// entries and multiply-accumulates them into a per-output-channel bank.
// Pipeline: accept (t) -> activation read strobe (t+1) -> accumulate (t+2).
// Optional feature macro: RF_GATHER_SAT_EN (saturating accumulate + sticky o_ovf).
module rf_gather_mac #(
   parameter int IA_ROW = 32,
   parameter int IA_COL = 32,
   parameter int K_NUM  = 16,
   parameter int ACC_W  = 24,
   parameter int IA_AW  = $clog2(IA_ROW*IA_COL)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_clear,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [6:0]               i_row,
   input  logic [6:0]               i_col,
   input  logic [6:0]               i_k,
   input  logic [7:0]               i_wt,
   input  logic                     i_last,
   output logic                     o_ia_req,
   output logic [IA_AW-1:0]         o_ia_addr,
   input  logic [7:0]               i_ia_data,
   input  logic [$clog2(K_NUM)-1:0] i_rd_k,
   output logic [ACC_W-1:0]         o_rd_psum,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [15:0]              o_mac_cnt,
   output logic [15:0]              o_skip_cnt,
   output logic                     o_ovf
);

   localparam int KW = $clog2(K_NUM);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                   state;
   logic                     ready;
   logic                     busy;
   logic                     done;
   logic                     drain_cnt;

   logic                     s1_v;
   logic [IA_AW-1:0]         s1_addr;
   logic [KW-1:0]            s1_k;
   logic [7:0]               s1_wt;
   logic                     s2_v;
   logic [KW-1:0]            s2_k;
   logic [7:0]               s2_wt;

   logic [15:0]              mac_cnt;
   logic [15:0]              skip_cnt;
   logic signed [ACC_W-1:0]  acc [K_NUM];

   logic                     start_go;
   logic                     accept;
   logic                     in_bounds;
   logic signed [15:0]       prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_cur;
   logic signed [ACC_W-1:0]  acc_new;

   assign start_go  = (state == S_IDLE) && i_start;
   assign accept    = i_valid && ready;
   // Negative (bit 6) coordinates are padding; so are rows/cols/channels past the edge.
   assign in_bounds = !i_row[6] && !i_col[6]
                      && (int'(i_row) < IA_ROW) && (int'(i_col) < IA_COL)
                      && (int'(i_k) < K_NUM);

   assign o_ready    = ready;
   assign o_busy     = busy;
   assign o_done     = done;
   assign o_ia_req   = s1_v;
   assign o_ia_addr  = s1_addr;
   assign o_mac_cnt  = mac_cnt;
   assign o_skip_cnt = skip_cnt;
   assign o_rd_psum  = acc[i_rd_k];

   // Pass sequencing: idle -> run -> two drain cycles -> done pulse -> idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_IDLE;
         ready     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         drain_cnt <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state <= S_RUN;
                  ready <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (accept && i_last) begin
                  state     <= S_DRAIN;
                  ready     <= 1'b0;
                  drain_cnt <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (drain_cnt) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: issue the activation read; dropped entries leave an empty slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_v    <= 1'b0;
         s1_addr <= '0;
         s1_k    <= '0;
         s1_wt   <= '0;
      end else begin
         s1_v <= accept && in_bounds;
         if (accept && in_bounds) begin
            s1_addr <= IA_AW'(int'(i_row) * IA_COL + int'(i_col));
            s1_k    <= i_k[KW-1:0];
            s1_wt   <= i_wt;
         end
      end
   end

   // Stage 2: hold channel/weight while the activation returns from SRAM.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_v  <= 1'b0;
         s2_k  <= '0;
         s2_wt <= '0;
      end else begin
         s2_v  <= s1_v;
         s2_k  <= s1_k;
         s2_wt <= s1_wt;
      end
   end

   assign prod     = $signed(s2_wt) * $signed(i_ia_data);
   assign prod_ext = ACC_W'(prod);
   assign acc_cur  = acc[s2_k];

`ifdef RF_GATHER_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W:0] sum_wide;
   logic                  clip;
   logic                  ovf;

   // One guard bit detects overflow; clip toward the sign of the true sum.
   assign sum_wide = (ACC_W+1)'(acc_cur) + (ACC_W+1)'(prod_ext);
   assign clip     = sum_wide[ACC_W] != sum_wide[ACC_W-1];
   assign acc_new  = clip ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
   assign o_ovf    = ovf;

   // Sticky clip flag, cleared at the start of each pass.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ovf <= 1'b0;
      end else if (start_go) begin
         ovf <= 1'b0;
      end else if (s2_v && clip) begin
         ovf <= 1'b1;
      end
   end
`else
   assign acc_new = acc_cur + prod_ext;
   assign o_ovf   = 1'b0;
`endif

   // Accumulator bank: optional clear at start, else single-cycle read-modify-write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < K_NUM; i++) acc[i] <= '0;
      end else if (start_go && i_clear) begin
         for (int i = 0; i < K_NUM; i++) acc[i] <= '0;
      end else if (s2_v) begin
         acc[s2_k] <= acc_new;
      end
   end

   // Per-pass counters: drops counted at acceptance, MACs at accumulate.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mac_cnt  <= '0;
         skip_cnt <= '0;
      end else if (start_go) begin
         mac_cnt  <= '0;
         skip_cnt <= '0;
      end else begin
         if (accept && !in_bounds) skip_cnt <= skip_cnt + 16'd1;
         if (s2_v)                 mac_cnt  <= mac_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_rf_gather_mac.sv
// Directed testbench for rf_gather_mac: a default instance (ACC_W=24) and a
// 16-bit accumulator instance share stimulus and the activation memory model.
module tb_rf_gather_mac;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic        valid = 1'b0;
   logic [6:0]  row = '0;
   logic [6:0]  col = '0;
   logic [6:0]  k = '0;
   logic [7:0]  wt = '0;
   logic        last = 1'b0;
   logic [3:0]  rd_k = '0;
   logic [7:0]  ia_data;

   logic        ready, ia_req, busy, done, ovf;
   logic [9:0]  ia_addr;
   logic [23:0] psum;
   logic [15:0] mac_cnt, skip_cnt;

   logic        ready16, ia_req16, busy16, done16, ovf16;
   logic [9:0]  ia_addr16;
   logic [15:0] psum16;
   logic [15:0] mac16, skip16;

   logic [7:0]  mem [0:1023];
   int          req_pulses = 0;
   int          req_base;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   rf_gather_mac dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
      .i_valid(valid), .o_ready(ready), .i_row(row), .i_col(col), .i_k(k),
      .i_wt(wt), .i_last(last), .o_ia_req(ia_req), .o_ia_addr(ia_addr),
      .i_ia_data(ia_data), .i_rd_k(rd_k), .o_rd_psum(psum), .o_busy(busy),
      .o_done(done), .o_mac_cnt(mac_cnt), .o_skip_cnt(skip_cnt), .o_ovf(ovf)
   );

   rf_gather_mac #(.ACC_W(16)) dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
      .i_valid(valid), .o_ready(ready16), .i_row(row), .i_col(col), .i_k(k),
      .i_wt(wt), .i_last(last), .o_ia_req(ia_req16), .o_ia_addr(ia_addr16),
      .i_ia_data(ia_data), .i_rd_k(rd_k), .o_rd_psum(psum16), .o_busy(busy16),
      .o_done(done16), .o_mac_cnt(mac16), .o_skip_cnt(skip16), .o_ovf(ovf16)
   );

   // Activation SRAM model: one-cycle read latency; filler value when idle.
   always @(posedge clk) begin
      ia_data <= ia_req ? mem[ia_addr] : 8'h55;
      if (ia_req) req_pulses <= req_pulses + 1;
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int idx);
      rd_k = 4'(idx);
      #1;
   endtask

   task automatic start_pass(input logic clr);
      start = 1'b1;
      clear = clr;
      tick();
      start = 1'b0;
      clear = 1'b0;
   endtask

   task automatic send(input logic [6:0] r, input logic [6:0] c, input logic [6:0] kk,
                       input logic [7:0] w, input logic l);
      valid = 1'b1;
      row = r; col = c; k = kk; wt = w; last = l;
      tick();
      valid = 1'b0;
      last = 1'b0;
   endtask

   // Single entry (2,3,k=1,wt=5) with activation 7; checks full timeline.
   task automatic run_single(input logic clr, input int exp_psum, input int prev_psum);
      start_pass(clr);
      $display("pass start clear=%0b", clr);
      check("run_ready", ready, 1);
      check("run_busy", busy, 1);
      check("mac_restart", mac_cnt, 0);
      check("skip_restart", skip_cnt, 0);
      send(7'd2, 7'd3, 7'd1, 8'd5, 1'b1);
      rd(1);
      check("t1_ia_req", ia_req, 1);
      check("t1_ia_addr", ia_addr, 67);
      check("t1_ready_drain", ready, 0);
      check("t1_psum_old", $signed(psum), prev_psum);
      tick();
      check("t2_psum_old", $signed(psum), prev_psum);
      check("t2_done", done, 0);
      check("t2_ia_req", ia_req, 0);
      tick();
      $display("entry (2,3,k1,wt5) -> psum=%0d mac=%0d done=%0b", $signed(psum), mac_cnt, done);
      check("t3_done", done, 1);
      check("t3_psum", $signed(psum), exp_psum);
      check("t3_mac", mac_cnt, 1);
      check("t3_skip", skip_cnt, 0);
      tick();
      check("after_done", done, 0);
      check("after_busy", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[67] = 8'd7;
      mem[1]  = 8'd10;
      mem[2]  = 8'd10;
      mem[3]  = 8'd10;
      mem[0]  = 8'd3;
      mem[32] = 8'd127;

      // Reset state
      #1 rst_n = 1'b0;
      tick(); tick();
      rd(1);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 0);
      check("rst_done", done, 0);
      check("rst_ia_req", ia_req, 0);
      check("rst_psum", $signed(psum), 0);
      check("rst_mac", mac_cnt, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      tick();

      // Entries offered while idle are not accepted
      send(7'd2, 7'd3, 7'd1, 8'd5, 1'b0);
      check("idle_no_req", ia_req, 0);
      check("idle_no_skip", skip_cnt, 0);
      $display("idle entry ignored");

      // Test 1 and second pass without clear
      run_single(1'b1, 35, 0);
      run_single(1'b0, 70, 35);

      // Back-to-back accumulation into one channel
      start_pass(1'b1);
      send(7'd0, 7'd1, 7'd4, 8'd2, 1'b0);
      send(7'd0, 7'd2, 7'd4, 8'd3, 1'b0);
      send(7'd0, 7'd3, 7'd4, 8'hFF, 1'b1);
      tick(); tick();
      rd(4);
      $display("b2b k=4 -> psum=%0d mac=%0d", $signed(psum), mac_cnt);
      check("b2b_done", done, 1);
      check("b2b_psum", $signed(psum), 40);
      check("b2b_mac", mac_cnt, 3);
      rd(1);
      check("b2b_clear_k1", $signed(psum), 0);
      tick();

      // Out-of-bounds drops
      req_base = req_pulses;
      start_pass(1'b1);
      send(7'h7F, 7'd0, 7'd0, 8'd9, 1'b0);
      send(7'd0, 7'd32, 7'd0, 8'd9, 1'b0);
      send(7'd0, 7'd0, 7'd16, 8'd9, 1'b0);
      send(7'd0, 7'd0, 7'd0, 8'd1, 1'b1);
      tick(); tick();
      rd(0);
      $display("drops -> skip=%0d mac=%0d psum0=%0d", skip_cnt, mac_cnt, $signed(psum));
      check("oob_done", done, 1);
      check("oob_skip", skip_cnt, 3);
      check("oob_mac", mac_cnt, 1);
      check("oob_psum", $signed(psum), 3);
      check("oob_req_pulses", req_pulses - req_base, 1);
      tick();

      // Overflow: 127*127 three times into k=0
      start_pass(1'b1);
      send(7'd1, 7'd0, 7'd0, 8'd127, 1'b0);
      send(7'd1, 7'd0, 7'd0, 8'd127, 1'b0);
      send(7'd1, 7'd0, 7'd0, 8'd127, 1'b1);
      tick(); tick();
      rd(0);
      $display("ovf -> psum24=%0d psum16=%0d ovf16=%0b", $signed(psum), $signed(psum16), ovf16);
      check("ovf_done16", done16, 1);
      check("ovf_busy16", busy16, 1);
      check("ovf_mac16", mac16, 3);
      check("ovf_skip16", skip16, 0);
      check("ovf_psum24", $signed(psum), 48387);
      check("ovf_flag24", ovf, 0);
`ifdef RF_GATHER_SAT_EN
      check("ovf_psum16", $signed(psum16), 32767);
      check("ovf_flag16", ovf16, 1);
`else
      check("ovf_psum16", $signed(psum16), -17149);
      check("ovf_flag16", ovf16, 0);
`endif
      tick();

      // Asynchronous reset with a read in flight
      start_pass(1'b0);
      check("rr_ready16", ready16, 1);
      send(7'd2, 7'd3, 7'd1, 8'd5, 1'b0);
      check("rr_ia_req", ia_req, 1);
      check("rr_ia_addr16", ia_addr16, 67);
      check("rr_ia_req16", ia_req16, 1);
      rst_n = 1'b0;
      #1;
      check("rr_busy", busy, 0);
      check("rr_ia_req_low", ia_req, 0);
      check("rr_ia_addr", ia_addr, 0);
      check("rr_psum0", $signed(psum), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      rd(1);
      $display("reset mid-pass -> psum1=%0d busy=%0b", $signed(psum), busy);
      check("rr_no_late_acc", $signed(psum), 0);
      check("rr_busy_after", busy, 0);
      check("rr_mac", mac_cnt, 0);

      // Normal operation after reset
      run_single(1'b0, 35, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
